mmio_port_unit: RTL and testbench

- Memory-mapped I/O block directly downstream of the single-cycle MIPS core.
- Consumes the core's ALU-computed address, store data and MemRead/MemWrite strobes; replaces the core's tied-off PortOut with a writable register.
- Presents PortIn to software as a synchronised, debounced value, with a sticky change flag and an interrupt line.
- Read data returns combinationally in the same cycle, so the single-cycle datapath needs no stall.

---
 rtl/mmio_pkg.sv | 20 ++
 rtl/mmio_port_unit_input_debouncer.sv | 87 ++++++++
 rtl/mmio_port_unit.sv | 98 +++++++++
 tb/tb_mmio_port_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants and types for the MMIO port unit.
// Register offsets are word indices taken from Address[3:2].
package mmio_pkg;

    localparam logic [1:0] OFS_PORT_OUT = 2'd0;
    localparam logic [1:0] OFS_PORT_IN  = 2'd1;
    localparam logic [1:0] OFS_STATUS   = 2'd2;
    localparam logic [1:0] OFS_CONFIG   = 2'd3;

    localparam int STAT_CHG_BIT = 0;
    localparam int CFG_IE_BIT   = 0;

    localparam int DB_CNT_W = 8;

    typedef enum logic {
        DB_STABLE,
        DB_COUNTING
    } db_state_t;

endpackage

// File: rtl/mmio_port_unit_input_debouncer.sv
// Two-flop synchroniser plus debounce FSM for the external input port.
// change_pulse is combinational, high in the cycle before the accepting edge.
module input_debouncer
    import mmio_pkg::*;
#(
    parameter int PORT_IN_WIDTH   = 8,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PORT_IN_WIDTH-1:0] i_port,
    output logic [PORT_IN_WIDTH-1:0] o_stable,
    output logic                     o_change_pulse
);

    localparam logic [DB_CNT_W-1:0] DB_LIMIT = DB_CNT_W'(DEBOUNCE_CYCLES);

    logic [PORT_IN_WIDTH-1:0] r_sync1;
    logic [PORT_IN_WIDTH-1:0] r_sync2;
    logic [PORT_IN_WIDTH-1:0] r_stable;
    logic [DB_CNT_W-1:0]      r_count;
    db_state_t                r_state;

    logic [PORT_IN_WIDTH-1:0] w_stable_next;
    logic [DB_CNT_W-1:0]      w_count_next;
    logic [DB_CNT_W-1:0]      w_count_inc;
    db_state_t                w_state_next;
    logic                     w_accept;

    // The edge that enters COUNTING is itself the first counted edge,
    // so acceptance is judged on the incremented count.
    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_stable_next = r_stable;
        w_accept      = 1'b0;
        w_count_inc   = r_count + 1'b1;
        unique case (r_state)
            DB_STABLE: begin
                w_count_next = '0;
                if (r_sync2 != r_stable) begin
                    if (DB_LIMIT == 8'd1) begin
                        w_accept = 1'b1;
                    end else begin
                        w_state_next = DB_COUNTING;
                        w_count_next = 8'd1;
                    end
                end
            end
            DB_COUNTING: begin
                if (r_sync2 == r_stable) begin
                    w_state_next = DB_STABLE;
                    w_count_next = '0;
                end else if (w_count_inc == DB_LIMIT) begin
                    w_accept = 1'b1;
                end else begin
                    w_count_next = w_count_inc;
                end
            end
        endcase
        if (w_accept) begin
            w_stable_next = r_sync2;
            w_count_next  = '0;
            w_state_next  = DB_STABLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_stable <= '0;
            r_count  <= '0;
            r_state  <= DB_STABLE;
        end else begin
            r_sync1  <= i_port;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_next;
            r_count  <= w_count_next;
            r_state  <= w_state_next;
        end
    end

    assign o_stable       = r_stable;
    assign o_change_pulse = w_accept;

endmodule

// File: rtl/mmio_port_unit.sv
// MMIO block behind the single-cycle core: output port, debounced input
// port, sticky change flag and change interrupt.
module mmio_port_unit
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h1001_0000,
    parameter int          PORT_IN_WIDTH   = 8,
    parameter int          DEBOUNCE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              Address,
    input  logic [31:0]              WriteData,
    input  logic                     MemWrite,
    input  logic                     MemRead,
    output logic [31:0]              ReadData,
    output logic                     Hit,
    input  logic [PORT_IN_WIDTH-1:0] PortIn,
    output logic [31:0]              PortOut,
    output logic                     IRQ
);

    logic [PORT_IN_WIDTH-1:0] w_stable;
    logic                     w_change;
    logic [1:0]               w_ofs;
    logic                     w_wr;
    logic                     w_chg_next;
    logic                     w_ie_next;
    logic                     w_unused_lsb;

    logic [31:0] r_port_out;
    logic        r_chg;
    logic        r_ie;
    logic        r_irq;

    input_debouncer #(
        .PORT_IN_WIDTH  (PORT_IN_WIDTH),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk           (clk),
        .reset         (reset),
        .i_port        (PortIn),
        .o_stable      (w_stable),
        .o_change_pulse(w_change)
    );

    // Window is 16-byte aligned, so only the upper 28 bits are compared.
    assign Hit          = (Address[31:4] == BASE_ADDR[31:4]);
    assign w_ofs        = Address[3:2];
    assign w_wr         = MemWrite & Hit;
    assign w_unused_lsb = ^Address[1:0];

    always_comb begin
        w_chg_next = r_chg;
        w_ie_next  = r_ie;
        if (w_wr && w_ofs == OFS_STATUS && WriteData[STAT_CHG_BIT]) begin
            w_chg_next = 1'b0;
        end
        if (w_change) begin
            w_chg_next = 1'b1;
        end
        if (w_wr && w_ofs == OFS_CONFIG) begin
            w_ie_next = WriteData[CFG_IE_BIT];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_port_out <= '0;
            r_chg      <= 1'b0;
            r_ie       <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr && w_ofs == OFS_PORT_OUT) begin
                r_port_out <= WriteData;
            end
            r_chg <= w_chg_next;
            r_ie  <= w_ie_next;
            r_irq <= w_chg_next & w_ie_next;
        end
    end

    always_comb begin
        ReadData = '0;
        if (MemRead && Hit) begin
            unique case (w_ofs)
                OFS_PORT_OUT: ReadData = r_port_out;
                OFS_PORT_IN:  ReadData = 32'(w_stable);
                OFS_STATUS:   ReadData = {31'b0, r_chg};
                OFS_CONFIG:   ReadData = {31'b0, r_ie};
            endcase
        end
    end

    assign PortOut = r_port_out;
    assign IRQ     = r_irq;

endmodule

// File: tb/tb_mmio_port_unit.sv
// Bench for mmio_port_unit: directed scenarios then random traffic,
// all checked against a run-length behavioural model.
module tb_mmio_port_unit;

    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam int          DB   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Address = '0;
    logic [31:0] WriteData = '0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [7:0]  PortIn = '0;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] PortOut;
    logic        IRQ;

    int total = 0;
    int bad = 0;

    logic [31:0] m_pout;
    logic [7:0]  m_stable;
    logic [7:0]  m_h1;
    logic [7:0]  m_h2;
    int          m_run;
    logic        m_chg;
    logic        m_ie;
    logic        m_irq;

    mmio_port_unit #(
        .BASE_ADDR      (BASE),
        .PORT_IN_WIDTH  (8),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .Address  (Address),
        .WriteData(WriteData),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .ReadData (ReadData),
        .Hit      (Hit),
        .PortIn   (PortIn),
        .PortOut  (PortOut),
        .IRQ      (IRQ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_hit(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'd15);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_hit(a)) return 32'h0;
        case ((a - BASE) >> 2)
            0:       return m_pout;
            1:       return {24'h0, m_stable};
            2:       return {31'h0, m_chg};
            default: return {31'h0, m_ie};
        endcase
    endfunction

    task automatic model_reset();
        m_pout = '0; m_stable = '0; m_h1 = '0; m_h2 = '0;
        m_run = 0; m_chg = 0; m_ie = 0; m_irq = 0;
    endtask

    // One clock: check combinational outputs, advance model, check state.
    task automatic tick();
        logic [7:0]  s;
        logic [31:0] ofs;
        logic        wr;
        logic        set;
        #1;
        chk("hit", {31'h0, Hit}, {31'h0, m_hit(Address)});
        chk("rdata", ReadData, MemRead ? m_read(Address) : 32'h0);
        wr  = MemWrite && m_hit(Address);
        ofs = (Address - BASE) >> 2;
        s = m_h2;
        m_h2 = m_h1;
        m_h1 = PortIn;
        set = 0;
        if (s != m_stable) begin
            m_run++;
            if (m_run == DB) begin
                m_stable = s;
                m_run = 0;
                set = 1;
            end
        end else begin
            m_run = 0;
        end
        if (wr && ofs == 0) m_pout = WriteData;
        if (wr && ofs == 3) m_ie = WriteData[0];
        if (set) m_chg = 1;
        else if (wr && ofs == 2 && WriteData[0]) m_chg = 0;
        m_irq = m_chg & m_ie;
        @(posedge clk);
        #1;
        chk("portout", PortOut, m_pout);
        chk("irq", {31'h0, IRQ}, {31'h0, m_irq});
    endtask

    task automatic idle();
        MemWrite = 0; MemRead = 0; Address = 32'h0;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        Address = a; WriteData = d; MemWrite = 1; MemRead = 0;
        tick();
        MemWrite = 0;
    endtask

    initial begin
        model_reset();
        PortIn = 8'hA5;
        #1 reset = 0;
        #2;
        chk("rst_portout", PortOut, 32'h0);
        chk("rst_irq", {31'h0, IRQ}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1;

        Address = BASE + 4; MemRead = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("pin_latency", ReadData, (i < 6) ? 32'h0 : 32'h0000_00A5);
        end
        Address = BASE + 8;
        #1 chk("chg_after_accept", ReadData, 32'h1);

        wr_reg(BASE + 8, 32'h1);
        wr_reg(BASE, 32'hDEAD_BEEF);
        chk("portout_write", PortOut, 32'hDEAD_BEEF);
        Address = BASE; MemRead = 1;
        #1 chk("portout_read", ReadData, 32'hDEAD_BEEF);
        MemWrite = 1; WriteData = 32'h1234_5678;
        #1 chk("rw_pre_edge", ReadData, 32'hDEAD_BEEF);
        tick();
        wr_reg(BASE, 32'hDEAD_BEEF);

        PortIn = 8'h00;
        idle();
        for (int i = 0; i < 10; i++) tick();
        wr_reg(BASE + 8, 32'h1);
        PortIn = 8'h01;
        for (int i = 0; i < 3; i++) tick();
        PortIn = 8'h00;
        for (int i = 0; i < 8; i++) tick();
        Address = BASE + 4; MemRead = 1;
        #1 chk("glitch_pin", ReadData, 32'h0);
        Address = BASE + 8;
        #1 chk("glitch_chg", ReadData, 32'h0);
        PortIn = 8'h01;
        Address = BASE + 4;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 6) chk("hold_pin", ReadData, 32'h1);
        end

        wr_reg(BASE + 8, 32'h1);
        wr_reg(BASE + 12, 32'h1);
        PortIn = 8'h02;
        for (int i = 1; i <= 6; i++) tick();
        chk("irq_set", {31'h0, IRQ}, 32'h1);
        PortIn = 8'h03;
        for (int i = 1; i <= 5; i++) tick();
        wr_reg(BASE + 8, 32'h1);
        Address = BASE + 8; MemRead = 1;
        #1 chk("collide_chg", ReadData, 32'h1);
        chk("collide_irq", {31'h0, IRQ}, 32'h1);
        wr_reg(BASE + 8, 32'h1);
        chk("w1c_irq", {31'h0, IRQ}, 32'h0);
        MemRead = 1;
        #1 chk("w1c_chg", ReadData, 32'h0);

        Address = BASE + 16; MemRead = 1; MemWrite = 1;
        WriteData = 32'h0BAD_0BAD;
        #1 chk("oow_hit", {31'h0, Hit}, 32'h0);
        chk("oow_rdata", ReadData, 32'h0);
        tick();
        Address = 32'h0;
        tick();
        chk("oow_portout", PortOut, 32'hDEAD_BEEF);
        idle();

        PortIn = 8'h55;
        for (int i = 0; i < 5; i++) tick();
        reset = 0;
        #2;
        model_reset();
        chk("midrst_portout", PortOut, 32'h0);
        chk("midrst_irq", {31'h0, IRQ}, 32'h0);
        @(posedge clk);
        #1 reset = 1;
        Address = BASE + 4; MemRead = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("midrst_latency", ReadData, (i < 6) ? 32'h0 : 32'h55);
        end

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0: Address = BASE + 32'd16;
                1: Address = BASE - 32'd4;
                2: Address = $urandom;
                default: Address = BASE + 32'($urandom_range(0, 15));
            endcase
            MemRead   = 1'($urandom_range(0, 1));
            MemWrite  = ($urandom_range(0, 9) < 3);
            WriteData = $urandom;
            if ($urandom_range(0, 7) == 0) PortIn = 8'($urandom_range(0, 3));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
